// File: rtl/mips_dmem_ctrl.sv
// Data-memory access controller: turns byte/half/word loads and stores from the
// datapath into word-aligned req/ack bus transfers with byte enables, stalling the core meanwhile.
module mips_dmem_ctrl #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [1:0]            mem_size,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] writedata,
   output logic [DATA_WIDTH-1:0] readdata,
   output logic                  stall,
   output logic                  misalign,
   output logic                  bus_err,
   output logic                  bus_req,
   output logic                  bus_we,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [3:0]            bus_be,
   output logic [DATA_WIDTH-1:0] bus_wdata,
   input  logic                  bus_ack,
   input  logic [DATA_WIDTH-1:0] bus_rdata
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t                  state_q, state_d;
   logic [15:0]             cnt_q, cnt_d;
   logic                    bus_req_q, bus_req_d;
   logic                    bus_we_q, bus_we_d;
   logic [ADDR_WIDTH-1:0]   bus_addr_q, bus_addr_d;
   logic [3:0]              bus_be_q, bus_be_d;
   logic [DATA_WIDTH-1:0]   bus_wdata_q, bus_wdata_d;
   logic [DATA_WIDTH-1:0]   readdata_q, readdata_d;
   logic                    bus_err_q, bus_err_d;
   logic [1:0]              off_q, off_d;
   logic [1:0]              size_q, size_d;
   logic                    is_load_q, is_load_d;

   logic                    access, misaligned, accept;
   logic [3:0]              be_calc;
   logic [DATA_WIDTH-1:0]   wdata_calc;
   logic [DATA_WIDTH-1:0]   rdata_lane;

   // Bus handshake: bus_req rises one edge after acceptance and stays high with
   // we/addr/be/wdata frozen until a cycle in which bus_ack=1 is sampled; bus_rdata
   // is only meaningful in that ack cycle. Ack outside REQ is ignored.
   always_comb begin
      access     = mem_read | mem_write;
      misaligned = ((mem_size == 2'b01) && addr[0]) ||
                   (mem_size[1] && (addr[1:0] != 2'b00));
      accept     = access && !misaligned;

      case (mem_size)
         2'b00:   be_calc = 4'b0001 << addr[1:0];
         2'b01:   be_calc = addr[1] ? 4'b1100 : 4'b0011;
         default: be_calc = 4'b1111;
      endcase

      case (mem_size)
         2'b00:   wdata_calc = {4{writedata[7:0]}};
         2'b01:   wdata_calc = {2{writedata[15:0]}};
         default: wdata_calc = writedata;
      endcase

      case (size_q)
         2'b00:   rdata_lane = {{(DATA_WIDTH-8){1'b0}}, bus_rdata[{off_q, 3'b000} +: 8]};
         2'b01:   rdata_lane = {{(DATA_WIDTH-16){1'b0}}, bus_rdata[{off_q[1], 4'b0000} +: 16]};
         default: rdata_lane = bus_rdata;
      endcase

      state_d     = state_q;
      cnt_d       = cnt_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_be_d    = bus_be_q;
      bus_wdata_d = bus_wdata_q;
      readdata_d  = readdata_q;
      bus_err_d   = 1'b0;
      off_d       = off_q;
      size_d      = size_q;
      is_load_d   = is_load_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d     = REQ;
               cnt_d       = 16'd0;
               bus_req_d   = 1'b1;
               bus_we_d    = mem_write;
               bus_addr_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
               bus_be_d    = be_calc;
               bus_wdata_d = wdata_calc;
               off_d       = addr[1:0];
               size_d      = mem_size;
               is_load_d   = !mem_write;
            end
         end
         REQ: begin
            cnt_d = cnt_q + 16'd1;
            // An ack in the expiry cycle still wins over the timeout.
            if (bus_ack) begin
               state_d   = DONE;
               bus_req_d = 1'b0;
               if (is_load_q) readdata_d = rdata_lane;
            end else if (cnt_q == TO_LAST) begin
               state_d   = DONE;
               bus_req_d = 1'b0;
               bus_err_d = 1'b1;
               if (is_load_q) readdata_d = '0;
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = 16'd0;
         end
         default: state_d = IDLE;
      endcase

      stall    = ((state_q == IDLE) && accept) || (state_q == REQ);
      misalign = (state_q == IDLE) && access && misaligned;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 16'd0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_be_q    <= 4'b0000;
         bus_wdata_q <= '0;
         readdata_q  <= '0;
         bus_err_q   <= 1'b0;
         off_q       <= 2'b00;
         size_q      <= 2'b00;
         is_load_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_be_q    <= bus_be_d;
         bus_wdata_q <= bus_wdata_d;
         readdata_q  <= readdata_d;
         bus_err_q   <= bus_err_d;
         off_q       <= off_d;
         size_q      <= size_d;
         is_load_q   <= is_load_d;
      end
   end

   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_be    = bus_be_q;
   assign bus_wdata = bus_wdata_q;
   assign readdata  = readdata_q;
   assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mips_dmem_ctrl.sv
// Bench for mips_dmem_ctrl: directed scenarios then randomized accesses, checked
// against a size/offset arithmetic model of lanes, enables and load results.
module tb_mips_dmem_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [1:0]  mem_size = 2'b00;
   logic [31:0] addr = '0;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic        stall, misalign, bus_err, bus_req, bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = '0;

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [31:0] model_rd = '0;
   logic [31:0] exp_q[$];

   mips_dmem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
      .addr(addr), .writedata(writedata), .readdata(readdata),
      .stall(stall), .misalign(misalign), .bus_err(bus_err),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_req();
      mem_read  = 1'b0;
      mem_write = 1'b0;
   endtask

   // Aligned access with a bus responder that acks after waitc wait cycles (or never).
   task automatic access(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rdat, input int waitc, input bit no_ack);
      logic [31:0] exp_addr, exp_be, exp_wd, exp_rdv;
      int          exp_req, st, rq, n;
      exp_addr = a & ~32'd3;
      case (sz)
         2'd0:    exp_be = 32'd1 << a[1:0];
         2'd1:    exp_be = 32'd3 << (a[1:0] & 2'b10);
         default: exp_be = 32'd15;
      endcase
      case (sz)
         2'd0:    exp_wd = {24'd0, wd[7:0]} * 32'h0101_0101;
         2'd1:    exp_wd = {16'd0, wd[15:0]} * 32'h0001_0001;
         default: exp_wd = wd;
      endcase
      case (sz)
         2'd0:    exp_rdv = (rdat >> (8 * a[1:0])) & 32'hFF;
         2'd1:    exp_rdv = (rdat >> (8 * (a[1:0] & 2'b10))) & 32'hFFFF;
         default: exp_rdv = rdat;
      endcase
      if (!wr) model_rd = no_ack ? 32'd0 : exp_rdv;
      exp_q.push_back(model_rd);
      exp_req = no_ack ? TO : waitc + 1;

      @(posedge clk); #1;
      mem_read = rd; mem_write = wr; mem_size = sz; addr = a; writedata = wd;
      st = 0; rq = 0; n = 0;
      forever begin
         @(negedge clk);
         n++;
         bus_ack = 1'b0;
         bus_rdata = $urandom;
         if (stall) st++;
         if (bus_req) begin
            rq++;
            chk("bus_we", 32'(bus_we), 32'(wr));
            chk("bus_addr", bus_addr, exp_addr);
            chk("bus_be", 32'(bus_be), exp_be);
            chk("bus_wdata", bus_wdata, exp_wd);
            chk("bus_err_req", 32'(bus_err), 32'd0);
            if (!no_ack && rq == waitc + 1) begin
               bus_ack = 1'b1;
               bus_rdata = rdat;
            end
         end
         if (!stall) break;
         if (n > TO + 6) begin
            chk("cycle_bound", 32'd1, 32'd0);
            break;
         end
      end
      bus_ack = 1'b0;
      chk("stall_cycles", 32'(st), 32'(exp_req + 1));
      chk("req_cycles", 32'(rq), 32'(exp_req));
      chk("done_bus_req", 32'(bus_req), 32'd0);
      chk("done_bus_err", 32'(bus_err), 32'(no_ack));
      chk("readdata", readdata, exp_q.pop_front());
      @(posedge clk); #1;
      clear_req();
      @(negedge clk);
      chk("err_pulse_end", 32'(bus_err), 32'd0);
      chk("idle_stall", 32'(stall), 32'd0);
   endtask

   task automatic mis_access(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic [31:0] a);
      @(posedge clk); #1;
      mem_read = rd; mem_write = wr; mem_size = sz; addr = a; writedata = $urandom;
      @(negedge clk);
      chk("misalign", 32'(misalign), 32'd1);
      chk("mis_stall", 32'(stall), 32'd0);
      @(negedge clk);
      chk("mis_bus_req", 32'(bus_req), 32'd0);
      chk("mis_readdata", readdata, model_rd);
      clear_req();
   endtask

   initial begin
      logic [1:0]  sz;
      logic [31:0] a;
      int          op;
      bit          mis;

      // reset state
      #3;
      chk("rst_bus_req", 32'(bus_req), 32'd0);
      chk("rst_bus_we", 32'(bus_we), 32'd0);
      chk("rst_bus_addr", bus_addr, 32'd0);
      chk("rst_bus_be", 32'(bus_be), 32'd0);
      chk("rst_bus_wdata", bus_wdata, 32'd0);
      chk("rst_readdata", readdata, 32'd0);
      chk("rst_bus_err", 32'(bus_err), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      @(posedge clk); #2 rst_n = 1'b1;

      access(1'b0, 1'b1, 2'd2, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
      access(1'b0, 1'b1, 2'd0, 32'h103, 32'h0000_00A5, 32'h0, 0, 1'b0);
      access(1'b1, 1'b0, 2'd1, 32'h22, 32'h0, 32'h8001_7FFF, 3, 1'b0);
      access(1'b0, 1'b1, 2'd1, 32'h10, 32'h1234_5678, 32'h0, 1, 1'b0);
      mis_access(1'b1, 1'b0, 2'd2, 32'h6);
      mis_access(1'b1, 1'b0, 2'd1, 32'h5);
      mis_access(1'b0, 1'b1, 2'd3, 32'h2);
      access(1'b1, 1'b0, 2'd2, 32'h40, 32'h0, 32'h0, 0, 1'b1);
      access(1'b1, 1'b0, 2'd3, 32'h44, 32'h0, 32'hCAFE_F00D, TO - 1, 1'b0);
      access(1'b1, 1'b1, 2'd2, 32'h48, 32'h5555_AAAA, 32'h0, 0, 1'b0);

      // ack while idle must be ignored
      @(posedge clk); #1;
      bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
      @(posedge clk); #1;
      bus_ack = 1'b0;
      @(negedge clk);
      chk("idle_ack_req", 32'(bus_req), 32'd0);
      chk("idle_ack_rd", readdata, model_rd);

      // reset while a request is outstanding
      @(posedge clk); #1;
      mem_read = 1'b1; mem_size = 2'd2; addr = 32'h80;
      @(posedge clk);
      @(negedge clk);
      chk("pre_rst_req", 32'(bus_req), 32'd1);
      rst_n = 1'b0;
      clear_req();
      #1;
      chk("async_rst_req", 32'(bus_req), 32'd0);
      chk("async_rst_stall", 32'(stall), 32'd0);
      model_rd = 32'd0;
      exp_q.delete();
      @(posedge clk); #2 rst_n = 1'b1;
      access(1'b1, 1'b0, 2'd0, 32'h1, 32'h0, 32'h0000_FF00, 0, 1'b0);

      // randomized accesses
      for (int i = 0; i < 40; i++) begin
         sz = 2'($urandom_range(0, 3));
         a = $urandom & 32'h0000_FFFF;
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz[1]) a[1:0] = 2'b00;
         end
         op = $urandom_range(0, 2);
         mis = ((sz == 2'd1) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
         if (mis)
            mis_access(op != 1, op != 0, sz, a);
         else
            access(op != 1, op != 0, sz, a, $urandom, $urandom,
                   $urandom_range(0, TO - 1), $urandom_range(0, 7) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mips_dmem_ctrl.md
Name: mips_dmem_ctrl

Overview:
Data-memory access controller placed directly downstream of mips_datapath. It consumes the datapath's aluout (address) and writedata, and returns readdata. It converts byte, halfword and word loads and stores into word-aligned transfers with byte enables on a req/ack memory bus. It also stalls the core while a transfer is outstanding.

Parameters:
ADDR_WIDTH, 32, byte address width on core and bus sides
DATA_WIDTH, 32, data word width (fixed 32; byte-lane logic assumes 4 lanes)
TIMEOUT_CYCLES, 255, max cycles waiting for bus_ack before aborting (1..2^16-1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_read  in  1  core load request, held while stall=1
mem_write  in  1  core store request, held while stall=1
mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
addr  in  ADDR_WIDTH  byte address (datapath aluout)
writedata  in  DATA_WIDTH  store data, right-aligned (datapath writedata)
readdata  out  DATA_WIDTH  load data, lane-extracted, zero-extended to 32
stall  out  1  core must hold PC and request
misalign  out  1  request rejected, address not size-aligned
bus_err  out  1  one-cycle pulse, transfer aborted by timeout
bus_req  out  1  bus request, registered
bus_we  out  1  1 write, 0 read
bus_addr  out  ADDR_WIDTH  word-aligned address (addr[1:0] forced 00)
bus_be  out  4  byte enables, bit k = byte lane k (little-endian)
bus_wdata  out  DATA_WIDTH  replicated store data
bus_ack  in  1  single-cycle transfer complete
bus_rdata  in  DATA_WIDTH  read data, valid with bus_ack

Behaviour:
- Reset (async, rst_n=0): state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, readdata=0, bus_err=0, timeout counter=0.
- A reset during REQ drops bus_req immediately. No completion is reported.
- FSM states IDLE, REQ, DONE.
- IDLE, valid request (mem_read|mem_write, aligned):
  - stall=1 combinationally.
  - Capture bus_we, bus_addr, bus_be and bus_wdata, plus lane offset and size for the load.
  - Next state REQ, with bus_req=1 from the next edge.
- REQ:
  - stall=1.
  - bus_req, bus_we, bus_addr, bus_be and bus_wdata are held stable.
  - Counter increments each cycle.
  - On bus_ack: for a load, register readdata from bus_rdata; go to DONE and set bus_req=0 at the next edge.
  - If the counter reaches TIMEOUT_CYCLES without ack: go to DONE, bus_err=1 for one cycle, readdata=0 for loads.
- DONE: stall=0 so the core advances exactly once, bus_req=0, then IDLE. The request is not re-accepted in DONE.
- Latency with ack in the first REQ cycle: request at cycle N, bus_req high at N+1, DONE at N+2, so stall is high for 2 cycles.
- readdata holds its value until the next load completes. Stores leave it unchanged.
- mem_read and mem_write both high: treated as a store.
- Alignment:
  - Half with addr[0]=1 is misaligned.
  - Word or size 11 with addr[1:0]!=00 is misaligned.
  - On a misaligned request in IDLE: misalign=1 combinationally, stall=0, no bus transaction, state stays IDLE.
- Byte enables:
  - byte: be = 1<<addr[1:0]
  - half: be = 0011 if addr[1]=0, else 1100
  - word: be = 1111
- Store data:
  - byte: writedata[7:0] replicated 4x
  - half: writedata[15:0] replicated 2x
  - word: as-is
- Load extraction:
  - byte: bus_rdata[8*off+:8] zero-extended
  - half: bus_rdata[16*addr[1]+:16] zero-extended
  - Sign extension is done downstream in the write-back path.
- bus_ack seen in IDLE or DONE is ignored.
- An ack arriving in the same cycle the counter expires counts as a successful ack; there is no bus_err.

Test Plan:
- SW addr=0x100, writedata=0xDEADBEEF, ack in first REQ cycle -> bus_addr=0x100, bus_be=1111, bus_wdata=0xDEADBEEF, bus_we=1; stall high for exactly 2 cycles.
- SB addr=0x103, writedata=0x000000A5 -> bus_addr=0x100, bus_be=1000, bus_wdata=0xA5A5A5A5.
- LH addr=0x22, bus_rdata=0x8001_7FFF, ack after 3 wait cycles -> readdata=0x00008001 in DONE; stall high for 5 cycles; readdata held afterwards.
- LW addr=0x6 -> misalign=1, stall=0, bus_req never rises. LH addr=0x5 -> misalign=1.
- LW addr=0x40 with no ack, TIMEOUT_CYCLES=4 -> bus_err one-cycle pulse, readdata=0, bus_req low, FSM back to IDLE.
- rst_n low while in REQ -> bus_req=0 immediately. After release, FSM is in IDLE and a new LB addr=0x1, bus_rdata=0x0000FF00 yields readdata=0x000000FF.
